// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter shared by the fetch and MEM stages.
// Data has fixed priority, and only one access is in flight at a time.
module mem_port_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    input  logic              if_cancel,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_ready,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_ready,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic              stall_if,
    output logic              stall_mem,
    output logic [CNT_W-1:0]  conflict_cnt
);

    typedef enum logic [1:0] {
        IDLE,
        BUSY_D,
        BUSY_I
    } state_t;

    state_t state;
    logic   drop;
    logic   d_win;
    logic   i_win;

    // A requester whose ready pulse is high is masked so it is not re-granted.
    always_comb begin
        d_win = d_req & ~d_ready;
        i_win = if_req & ~if_ready & ~if_cancel & ~d_win;
    end

    assign stall_mem = d_req & ~d_ready;
    assign stall_if  = (if_req & ~if_ready) | stall_mem;

    // Arbitration FSM with registered bus, read data and ready outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= IDLE;
            drop         <= 1'b0;
            mem_en       <= 1'b0;
            mem_we       <= 1'b0;
            mem_addr     <= '0;
            mem_wdata    <= '0;
            if_rdata     <= '0;
            d_rdata      <= '0;
            if_ready     <= 1'b0;
            d_ready      <= 1'b0;
            conflict_cnt <= '0;
        end else begin
            if_ready <= 1'b0;
            d_ready  <= 1'b0;
            unique case (state)
                IDLE: begin
                    drop <= 1'b0;
                    if (d_win) begin
                        state     <= BUSY_D;
                        mem_en    <= 1'b1;
                        mem_we    <= d_we;
                        mem_addr  <= d_addr;
                        mem_wdata <= d_wdata;
                        if (if_req && conflict_cnt != '1)
                            conflict_cnt <= conflict_cnt + 1'b1;
                    end else if (i_win) begin
                        state     <= BUSY_I;
                        mem_en    <= 1'b1;
                        mem_we    <= 1'b0;
                        mem_addr  <= if_addr;
                        mem_wdata <= '0;
                    end
                end
                BUSY_D: begin
                    if (mem_ack) begin
                        state   <= IDLE;
                        mem_en  <= 1'b0;
                        d_ready <= 1'b1;
                        if (!mem_we)
                            d_rdata <= mem_rdata;
                    end
                end
                BUSY_I: begin
                    if (if_cancel)
                        drop <= 1'b1;
                    if (mem_ack) begin
                        state  <= IDLE;
                        mem_en <= 1'b0;
                        drop   <= 1'b0;
                        if (!drop && !if_cancel) begin
                            if_ready <= 1'b1;
                            if_rdata <= mem_rdata;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_mem_port_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int CW = 4;

    logic          clk;
    logic          rst;
    logic          if_req;
    logic [AW-1:0] if_addr;
    logic          if_cancel;
    logic [DW-1:0] if_rdata;
    logic          if_ready;
    logic          d_req;
    logic          d_we;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata;
    logic [DW-1:0] d_rdata;
    logic          d_ready;
    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic          mem_ack;
    logic          stall_if;
    logic          stall_mem;
    logic [CW-1:0] conflict_cnt;

    int n_cmp;
    int n_bad;

    mem_port_arbiter #(
        .ADDR_W(AW),
        .DATA_W(DW),
        .CNT_W (CW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .if_req      (if_req),
        .if_addr     (if_addr),
        .if_cancel   (if_cancel),
        .if_rdata    (if_rdata),
        .if_ready    (if_ready),
        .d_req       (d_req),
        .d_we        (d_we),
        .d_addr      (d_addr),
        .d_wdata     (d_wdata),
        .d_rdata     (d_rdata),
        .d_ready     (d_ready),
        .mem_en      (mem_en),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_rdata   (mem_rdata),
        .mem_ack     (mem_ack),
        .stall_if    (stall_if),
        .stall_mem   (stall_mem),
        .conflict_cnt(conflict_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b0;
        if_req = 0; if_addr = '0; if_cancel = 0;
        d_req = 0; d_we = 0; d_addr = '0; d_wdata = '0;
        mem_rdata = '0; mem_ack = 0;
        tick();
        n_cmp++;
        if ({mem_en, mem_we, if_ready, d_ready} !== 4'b0) begin
            $display("FAIL reset_ctl: got %b want 0000",
                     {mem_en, mem_we, if_ready, d_ready});
            n_bad++;
        end
        n_cmp++;
        if (mem_addr !== 0 || mem_wdata !== 0 || if_rdata !== 0
            || d_rdata !== 0 || conflict_cnt !== 0) begin
            $display("FAIL reset_data: addr %h wd %h ir %h dr %h cnt %h",
                     mem_addr, mem_wdata, if_rdata, d_rdata, conflict_cnt);
            n_bad++;
        end
        tick();
        rst = 1'b1;
        tick();
    endtask

    task automatic test_lone_fetch();
        if_req = 1; if_addr = 32'h40;
        tick();
        n_cmp++;
        if (mem_en !== 1 || mem_we !== 0 || mem_addr !== 32'h40
            || stall_if !== 1) begin
            $display("FAIL fetch_busy1: en %b we %b addr %h st %b want 1 0 40 1",
                     mem_en, mem_we, mem_addr, stall_if);
            n_bad++;
        end
        tick();
        n_cmp++;
        if (mem_en !== 1 || if_ready !== 0 || stall_if !== 1) begin
            $display("FAIL fetch_busy2: en %b rdy %b st %b want 1 0 1",
                     mem_en, if_ready, stall_if);
            n_bad++;
        end
        mem_ack = 1; mem_rdata = 32'h8C220004;
        tick();
        n_cmp++;
        if (if_ready !== 1 || if_rdata !== 32'h8C220004 || mem_en !== 0
            || stall_if !== 0) begin
            $display("FAIL fetch_ready: rdy %b data %h en %b st %b want 1 8c220004 0 0",
                     if_ready, if_rdata, mem_en, stall_if);
            n_bad++;
        end
        mem_ack = 0; mem_rdata = '0; if_req = 0;
        tick();
        n_cmp++;
        if (if_ready !== 0 || mem_en !== 0) begin
            $display("FAIL fetch_after: rdy %b en %b want 0 0", if_ready, mem_en);
            n_bad++;
        end
    endtask

    task automatic test_conflict();
        logic [3:0] en_seq;
        if_req = 1; if_addr = 32'h44;
        d_req = 1; d_we = 0; d_addr = 32'h200;
        tick();
        en_seq[0] = mem_en;
        n_cmp++;
        if (mem_addr !== 32'h200 || mem_we !== 0 || conflict_cnt !== 1) begin
            $display("FAIL conf_grant: addr %h we %b cnt %0d want 200 0 1",
                     mem_addr, mem_we, conflict_cnt);
            n_bad++;
        end
        tick();
        en_seq[1] = mem_en;
        mem_ack = 1; mem_rdata = 32'h11112222;
        tick();
        en_seq[2] = mem_en;
        n_cmp++;
        if (d_ready !== 1 || d_rdata !== 32'h11112222 || if_ready !== 0) begin
            $display("FAIL conf_load: drdy %b data %h irdy %b want 1 11112222 0",
                     d_ready, d_rdata, if_ready);
            n_bad++;
        end
        mem_ack = 0; d_req = 0;
        tick();
        en_seq[3] = mem_en;
        n_cmp++;
        if (en_seq !== 4'b1011) begin
            $display("FAIL conf_en_seq: got %b want 1011", en_seq);
            n_bad++;
        end
        n_cmp++;
        if (mem_addr !== 32'h44 || mem_we !== 0) begin
            $display("FAIL conf_fetch: addr %h we %b want 44 0", mem_addr, mem_we);
            n_bad++;
        end
        tick();
        mem_ack = 1; mem_rdata = 32'h33334444;
        tick();
        n_cmp++;
        if (if_ready !== 1 || if_rdata !== 32'h33334444 || conflict_cnt !== 1) begin
            $display("FAIL conf_done: rdy %b data %h cnt %0d want 1 33334444 1",
                     if_ready, if_rdata, conflict_cnt);
            n_bad++;
        end
        mem_ack = 0; if_req = 0;
        tick();
    endtask

    task automatic test_store();
        int bad_hold;
        bad_hold = 0;
        d_req = 1; d_we = 1; d_addr = 32'h100; d_wdata = 32'hDEADBEEF;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (mem_en !== 1 || mem_we !== 1 || mem_addr !== 32'h100
                || mem_wdata !== 32'hDEADBEEF || stall_mem !== 1)
                bad_hold++;
        end
        n_cmp++;
        if (bad_hold !== 0) begin
            $display("FAIL store_hold: %0d bad cycles want 0", bad_hold);
            n_bad++;
        end
        mem_ack = 1; mem_rdata = 32'hBADBAD00;
        tick();
        n_cmp++;
        if (d_ready !== 1 || d_rdata !== 32'h11112222 || mem_en !== 0
            || stall_mem !== 0) begin
            $display("FAIL store_ready: rdy %b data %h en %b st %b want 1 11112222 0 0",
                     d_ready, d_rdata, mem_en, stall_mem);
            n_bad++;
        end
        mem_ack = 0; d_req = 0; d_we = 0;
        tick();
        n_cmp++;
        if (d_ready !== 0 || mem_en !== 0) begin
            $display("FAIL store_after: rdy %b en %b want 0 0", d_ready, mem_en);
            n_bad++;
        end
    endtask

    task automatic test_cancel();
        if_req = 1; if_addr = 32'h60; if_cancel = 1;
        tick();
        n_cmp++;
        if (mem_en !== 0) begin
            $display("FAIL cancel_idle: en %b want 0", mem_en);
            n_bad++;
        end
        if_cancel = 0;
        tick();
        if_cancel = 1;
        tick();
        if_cancel = 0; if_req = 0;
        mem_ack = 1; mem_rdata = 32'hCAFECAFE;
        tick();
        n_cmp++;
        if (if_ready !== 0 || if_rdata !== 32'h33334444 || mem_en !== 0) begin
            $display("FAIL cancel_drop: rdy %b data %h en %b want 0 33334444 0",
                     if_ready, if_rdata, mem_en);
            n_bad++;
        end
        mem_ack = 0; if_req = 1; if_addr = 32'h80;
        tick();
        n_cmp++;
        if (mem_en !== 1 || mem_addr !== 32'h80) begin
            $display("FAIL cancel_regrant: en %b addr %h want 1 80", mem_en, mem_addr);
            n_bad++;
        end
        mem_ack = 1; mem_rdata = 32'h0000ABCD;
        tick();
        n_cmp++;
        if (if_ready !== 1 || if_rdata !== 32'h0000ABCD) begin
            $display("FAIL cancel_next: rdy %b data %h want 1 0000abcd",
                     if_ready, if_rdata);
            n_bad++;
        end
        mem_ack = 0; if_req = 0;
        tick();
    endtask

    task automatic test_reset_mid();
        d_req = 1; d_we = 0; d_addr = 32'h300;
        tick();
        n_cmp++;
        if (mem_en !== 1 || mem_addr !== 32'h300) begin
            $display("FAIL rmid_busy: en %b addr %h want 1 300", mem_en, mem_addr);
            n_bad++;
        end
        #2 rst = 1'b0;
        #1;
        n_cmp++;
        if (mem_en !== 0 || mem_addr !== 0 || if_rdata !== 0 || d_rdata !== 0) begin
            $display("FAIL rmid_clear: en %b addr %h ir %h dr %h want all 0",
                     mem_en, mem_addr, if_rdata, d_rdata);
            n_bad++;
        end
        d_req = 0;
        tick();
        rst = 1'b1;
        mem_ack = 1; mem_rdata = 32'h55555555;
        tick();
        mem_ack = 0;
        n_cmp++;
        if (d_ready !== 0 || if_ready !== 0 || mem_en !== 0 || d_rdata !== 0) begin
            $display("FAIL rmid_stray: drdy %b irdy %b en %b dr %h want 0 0 0 0",
                     d_ready, if_ready, mem_en, d_rdata);
            n_bad++;
        end
        tick();
    endtask

    task automatic test_saturation();
        int both;
        both = 0;
        if_req = 1; if_addr = 32'h40;
        d_req = 1; d_we = 0; d_addr = 32'h200;
        mem_ack = 1;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (if_ready && d_ready) both++;
        end
        n_cmp++;
        if (conflict_cnt !== 4'd2) begin
            $display("FAIL sat_mid: cnt %0d want 2", conflict_cnt);
            n_bad++;
        end
        for (int i = 0; i < 80; i++) begin
            tick();
            if (if_ready && d_ready) both++;
        end
        n_cmp++;
        if (conflict_cnt !== 4'hF) begin
            $display("FAIL sat_full: cnt %h want f", conflict_cnt);
            n_bad++;
        end
        n_cmp++;
        if (both !== 0) begin
            $display("FAIL sat_ready_excl: %0d overlaps want 0", both);
            n_bad++;
        end
        if_req = 0; d_req = 0; mem_ack = 0;
        tick();
        tick();
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        test_reset();
        test_lone_fetch();
        test_conflict();
        test_store();
        test_cancel();
        test_reset_mid();
        test_saturation();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares a single unified instruction/data memory port between the IF stage (instruction fetch) and the MEM stage (lw/sw) of the 5-stage MIPS pipeline. Only one access is in flight at a time. A small FSM grants one requester at a time and holds the memory handshake until `mem_ack`. The block returns read data and a one-cycle ready pulse, and produces the stall signals that freeze PC/IF-ID (fetch side) and the whole pipeline (data side) while an access is pending. Sits between the pipeline's fetch/MEM stages and the memory model, alongside the control unit.

## Interface
- `ADDR_W`, 32, address width.
- `DATA_W`, 32, data width.
- `CNT_W`, 16, width of the conflict counter.

Ports:
- `clk`  in  1  single clock; all state updates on rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `if_req`  in  1  fetch request; held until `if_ready`.
- `if_addr`  in  ADDR_W  fetch address (PC).
- `if_cancel`  in  1  fetch squash (taken jump/branch); discards the current or pending fetch.
- `if_rdata`  out  DATA_W  fetched instruction; valid when `if_ready`=1.
- `if_ready`  out  1  one-cycle fetch completion pulse.
- `d_req`  in  1  data request (memRead|memWrite); held until `d_ready`.
- `d_we`  in  1  1 = store, 0 = load.
- `d_addr`  in  ADDR_W  data address.
- `d_wdata`  in  DATA_W  store data.
- `d_rdata`  out  DATA_W  load data; valid when `d_ready`=1.
- `d_ready`  out  1  one-cycle data completion pulse.
- `mem_en`  out  1  memory access strobe; held until ack.
- `mem_we`  out  1  memory write enable.
- `mem_addr`  out  ADDR_W  memory address.
- `mem_wdata`  out  DATA_W  memory write data.
- `mem_rdata`  in  DATA_W  memory read data; valid with `mem_ack`.
- `mem_ack`  in  1  memory completion; one cycle.
- `stall_if`  out  1  freeze PC and IF/ID.
- `stall_mem`  out  1  freeze entire pipeline.
- `conflict_cnt`  out  CNT_W  saturating count of cycles with fetch blocked by data.

## Operation
- FSM states: IDLE, BUSY_D, BUSY_I.
- **IDLE:**
  - `d_req`=1 → BUSY_D. Data has fixed priority, because MEM holds the older instruction.
  - Else `if_req`=1 and `if_cancel`=0 → BUSY_I.
  - Else stay in IDLE.
- **On grant:** register `mem_addr`/`mem_we`/`mem_wdata` from the winner and set `mem_en`=1. For a fetch grant, `mem_we`=0 and `mem_wdata`=0.
- **BUSY_x:** hold all `mem_*` outputs stable. When `mem_ack`=1 is sampled:
  - Capture `mem_rdata` into `x_rdata`.
  - Pulse `x_ready` next cycle.
  - Drop `mem_en` and return to IDLE.
  - For a store, `d_rdata` is unchanged.
- **Cancel:**
  - `if_cancel`=1 in BUSY_I sets a `drop` flag. The bus transaction still completes; `if_ready` is suppressed and `if_rdata` is not updated.
  - `if_cancel`=1 in IDLE blocks the fetch grant that cycle.
  - `drop` clears on return to IDLE.
- **Completing requester masked:** during the cycle its ready pulse is high, that requester's request is ignored for arbitration, so a held `req` is not re-granted.
- **Stall outputs (combinational):**
  - `stall_mem` = `d_req` & ~`d_ready`.
  - `stall_if` = (`if_req` & ~`if_ready`) | `stall_mem`.
- **conflict_cnt:** +1 on each cycle with `if_req`=1, `d_req`=1, state IDLE, and data granted. Saturates at all-ones.
- A `mem_ack` arriving in IDLE is ignored.

## Timing
- **Reset (async, `rst`=0):**
  - State = IDLE.
  - `mem_en`, `mem_we`, `mem_addr`, `mem_wdata` = 0.
  - `if_rdata`, `d_rdata` = 0.
  - `if_ready`, `d_ready` = 0.
  - `drop` = 0; `conflict_cnt` = 0.
- A reset mid-transaction aborts the transaction immediately: `mem_en` drops and no ready pulse follows.
- **Latency:**
  - Request sampled in IDLE at edge N → `mem_en`=1 from N+1.
  - Ack sampled at edge M → `x_ready`=1 and `x_rdata` valid in cycle M+1, with `mem_en`=0.
  - Minimum request-to-ready is 2 cycles, with ack in the first BUSY cycle.
- **Back-to-back:** the next grant is decided in the ready cycle (M+1), so the second `mem_en` rises at M+2. There is one idle bus cycle between accesses.
- **Simultaneous `d_req` and `if_req` in IDLE:**
  - Data is served first; fetch follows immediately after.
  - `conflict_cnt` increments once per such IDLE cycle.
- **Ready pulses:** exactly one cycle each. The two ready pulses are never high together.

## Test plan
- **Lone fetch:** `if_req`=1, `if_addr`=0x40; ack on the 2nd BUSY cycle with `mem_rdata`=0x8C220004 → `mem_en` high for 2 cycles, `mem_we`=0, `if_ready` pulses once with `if_rdata`=0x8C220004; `stall_if`=1 until that pulse.
- **Store:** `d_req`=1, `d_we`=1, `d_addr`=0x100, `d_wdata`=0xDEADBEEF; ack after 3 cycles → `mem_we`=1 and address/data stable for 3 cycles, `d_ready` pulses once, `stall_mem`=1 throughout.
- **Conflict:** `if_req` and `d_req` (load 0x200) rise together; ack latency 1 → load completes first, then fetch; `mem_en` rises at cycles 1 and 4, `conflict_cnt`=1.
- **Cancel:** `if_cancel` pulses during BUSY_I → ack still consumed, `if_ready` stays 0, `if_rdata` holds its old value; a new `if_req` (0x80) is granted afterwards and completes normally.
- **Reset mid-access:** `rst`=0 while in BUSY_D → all outputs 0 immediately; after release, a stray `mem_ack` is ignored and no ready pulse appears.
- **Saturation:** force 2^16+5 conflict cycles → `conflict_cnt`=0xFFFF, no wrap.
